// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the data-cache controller slice.
// Holds the controller state encoding, address offset widths, the
// word counter width and the 4-word line size.
package dcache_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned BYTE_OFF_W = 1;  // Addr[0], ignored
  localparam int unsigned WORD_OFF_W = 2;  // word within a line, also the fill/write-back counter width
  localparam int unsigned IDX_LSB    = BYTE_OFF_W + WORD_OFF_W;

  localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB,
    ALLOC,
    DONE
  } state_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: backing-memory word bus of the data cache.
//   mem_req   request a word transfer (held until mem_ack)
//   mem_we    1 = write-back word, 0 = fill word
//   mem_addr  word-aligned byte address
//   mem_wdata write-back data
//   mem_ack   transfer completes on this clock edge
//   mem_rdata fill data, valid with mem_ack
// master = cache controller, slave = memory.
interface dcache_ctrl_if;
  import dcache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: direct-mapped line storage (valid, dirty, tag and
// 4 x 16-bit data per line). Combinational read of one line/word,
// single write port.
//   rdIndex/rdWord      read select -> rdValid, rdDirty, rdTag, rdData
//   wrEn                write one data word at wrIndex/wrWord
//   wrFillLine          with wrEn: install wrTag, valid=1, dirty=0
//   wrSetDirty          with wrEn: mark line dirty (store)
// Reset clears valid and dirty only; tag and data arrays keep contents.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 13 - INDEX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    rdIndex,
  input  logic [WORD_OFF_W-1:0] rdWord,
  output logic                  rdValid,
  output logic                  rdDirty,
  output logic [TAG_W-1:0]      rdTag,
  output logic [WORD_W-1:0]     rdData,
  input  logic                  wrEn,
  input  logic [INDEX_W-1:0]    wrIndex,
  input  logic [WORD_OFF_W-1:0] wrWord,
  input  logic [WORD_W-1:0]     wrData,
  input  logic                  wrSetDirty,
  input  logic                  wrFillLine,
  input  logic [TAG_W-1:0]      wrTag
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]  validBits;
  logic [LINES-1:0]  dirtyBits;
  logic [TAG_W-1:0]  tagMem  [LINES];
  logic [WORD_W-1:0] dataMem [LINES][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (wrEn) begin
      if (wrFillLine) begin
        validBits[wrIndex] <= 1'b1;
        dirtyBits[wrIndex] <= 1'b0;
      end else if (wrSetDirty) begin
        dirtyBits[wrIndex] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      dataMem[wrIndex][wrWord] <= wrData;
      if (wrFillLine) tagMem[wrIndex] <= wrTag;
    end
  end

  assign rdValid = validBits[rdIndex];
  assign rdDirty = dirtyBits[rdIndex];
  assign rdTag   = tagMem[rdIndex];
  assign rdData  = dataMem[rdIndex][rdWord];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache
// controller, one access in flight.
//   clk, rst            clock, synchronous active-high reset
//   Addr, DataIn        byte address / store data (latched on accept)
//   Rd, Wr              load / store request (Wr wins if both)
//   DataOut, Done       load data qualified by one-cycle Done pulse
//   CacheHit            Done was a hit
//   Stall               controller busy (miss, write-back, fill)
//   DCacheReq/DCacheHit perf pulses, live only with DCACHE_PERF_EN
//   mem                 backing-memory word bus (dcache_ctrl_if.master)
// Macro DCACHE_PERF_EN: enables DCacheReq/DCacheHit, else tied 0.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [WORD_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [WORD_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              DCacheReq,
  output logic              DCacheHit,
  dcache_ctrl_if.master     mem
);

  localparam int unsigned TAG_W = ADDR_W - IDX_LSB - INDEX_W;

  state_t state, nextState;
  logic [WORD_OFF_W-1:0] wordCnt;

  logic [TAG_W-1:0]      reqTag;
  logic [INDEX_W-1:0]    reqIndex;
  logic [WORD_OFF_W-1:0] reqWord;
  logic [WORD_W-1:0]     reqData;
  logic                  reqWr;

  logic                  rdValid, rdDirty;
  logic [TAG_W-1:0]      rdTag;
  logic [WORD_W-1:0]     rdData;
  logic [WORD_OFF_W-1:0] rdWord;
  logic                  hit;

  logic                  wrEn, wrSetDirty, wrFillLine;
  logic [WORD_OFF_W-1:0] wrWord;
  logic [WORD_W-1:0]     wrData;

  logic                  memReq, memWe;
  logic [ADDR_W-1:0]     memAddr;
  logic [WORD_W-1:0]     memWdata;

  logic                  unusedAddrBit;
  assign unusedAddrBit = Addr[0];

  dcache_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) lines (
    .clk        (clk),
    .rst        (rst),
    .rdIndex    (reqIndex),
    .rdWord     (rdWord),
    .rdValid    (rdValid),
    .rdDirty    (rdDirty),
    .rdTag      (rdTag),
    .rdData     (rdData),
    .wrEn       (wrEn),
    .wrIndex    (reqIndex),
    .wrWord     (wrWord),
    .wrData     (wrData),
    .wrSetDirty (wrSetDirty),
    .wrFillLine (wrFillLine),
    .wrTag      (reqTag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wordCnt <= '0;
    end else begin
      state <= nextState;
      if ((state == WB || state == ALLOC) && mem.mem_ack) wordCnt <= wordCnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && (Rd || Wr)) begin
      reqTag   <= Addr[ADDR_W-1 -: TAG_W];
      reqIndex <= Addr[IDX_LSB +: INDEX_W];
      reqWord  <= Addr[BYTE_OFF_W +: WORD_OFF_W];
      reqData  <= DataIn;
      reqWr    <= Wr;
    end
  end

  // During write-back the victim line is read word by word; otherwise
  // the requested word is read.
  assign rdWord = (state == WB) ? wordCnt : reqWord;
  assign hit    = rdValid && (rdTag == reqTag);

  always_comb begin
    nextState  = state;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    DataOut    = '0;
    wrEn       = 1'b0;
    wrSetDirty = 1'b0;
    wrFillLine = 1'b0;
    wrWord     = reqWord;
    wrData     = reqData;
    memReq     = 1'b0;
    memWe      = 1'b0;
    memAddr    = '0;
    memWdata   = '0;
    unique case (state)
      IDLE: if (Rd || Wr) nextState = COMPARE;
      COMPARE: begin
        if (hit) begin
          Done      = 1'b1;
          CacheHit  = 1'b1;
          nextState = IDLE;
          if (reqWr) begin
            wrEn       = 1'b1;
            wrSetDirty = 1'b1;
          end else begin
            DataOut = rdData;
          end
        end else begin
          Stall     = 1'b1;
          nextState = (rdValid && rdDirty) ? WB : ALLOC;
        end
      end
      WB: begin
        Stall    = 1'b1;
        memReq   = 1'b1;
        memWe    = 1'b1;
        memAddr  = {rdTag, reqIndex, wordCnt, 1'b0};
        memWdata = rdData;
        if (mem.mem_ack && wordCnt == LAST_WORD) nextState = ALLOC;
      end
      ALLOC: begin
        Stall   = 1'b1;
        memReq  = 1'b1;
        memAddr = {reqTag, reqIndex, wordCnt, 1'b0};
        if (mem.mem_ack) begin
          wrEn   = 1'b1;
          wrWord = wordCnt;
          wrData = mem.mem_rdata;
          if (wordCnt == LAST_WORD) begin
            wrFillLine = 1'b1;
            nextState  = DONE;
          end
        end
      end
      DONE: begin
        Done      = 1'b1;
        nextState = IDLE;
        if (reqWr) begin
          wrEn       = 1'b1;
          wrSetDirty = 1'b1;
        end else begin
          DataOut = rdData;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign mem.mem_req   = memReq;
  assign mem.mem_we    = memWe;
  assign mem.mem_addr  = memAddr;
  assign mem.mem_wdata = memWdata;

`ifdef DCACHE_PERF_EN
  // COMPARE always lasts exactly one cycle, so it marks each accepted access once.
  assign DCacheReq = (state == COMPARE);
  assign DCacheHit = (state == COMPARE) && hit;
`else
  assign DCacheReq = 1'b0;
  assign DCacheHit = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl with a behavioural
// cache/memory reference model and a configurable-latency memory.
module tb_dcache_ctrl;
  import dcache_pkg::*;

`ifdef DCACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, DCacheReq, DCacheHit;

  dcache_ctrl_if memIf ();

  dcache_ctrl #(.INDEX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .Rd        (Rd),
    .Wr        (Wr),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .DCacheReq (DCacheReq),
    .DCacheHit (DCacheHit),
    .mem       (memIf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory and reference model
  logic [15:0] backMem [32768];
  logic [15:0] refMem  [32768];
  bit          refValid [16];
  bit          refDirty [16];
  logic [8:0]  refTag   [16];
  logic [15:0] refData  [16][4];

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } xfer_t;
  xfer_t memLog[$];

  int          ackDelay = 0;
  bit          strayAck = 1'b0;
  int          waitCnt = 0;
  logic [15:0] holdAddr;

  // Memory responder: ack after ackDelay wait cycles; decisions made on the
  // falling edge so the DUT sees a settled mem_ack at the next rising edge.
  initial begin
    memIf.mem_ack   = 1'b0;
    memIf.mem_rdata = '0;
  end
  always @(negedge clk) begin
    memIf.mem_ack = 1'b0;
    if (!rst && memIf.mem_req === 1'b1) begin
      if (waitCnt == 0) holdAddr = memIf.mem_addr;
      else begin
        checks++;
        if (memIf.mem_addr !== holdAddr) begin
          failures++;
          $display("FAIL mem_addr_stable got=%h want=%h", memIf.mem_addr, holdAddr);
        end
      end
      if (waitCnt >= ackDelay) begin
        memIf.mem_ack   = 1'b1;
        memIf.mem_rdata = backMem[memIf.mem_addr[15:1]];
        if (memIf.mem_we) backMem[memIf.mem_addr[15:1]] = memIf.mem_wdata;
        memLog.push_back('{memIf.mem_we, memIf.mem_addr, memIf.mem_wdata});
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
      if (strayAck) begin
        memIf.mem_ack   = 1'b1;
        memIf.mem_rdata = 16'($urandom);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      refValid[i] = 1'b0;
      refDirty[i] = 1'b0;
    end
  endtask

  // One access: drive, observe until Done, compare against the model, update the model.
  task automatic run_access(input bit isWr, input bit both, input logic [15:0] a,
                            input logic [15:0] d, input string name);
    logic [8:0]  tag;
    logic [3:0]  idx;
    logic [1:0]  w;
    bit          expHit, dirtyVictim, got, dcHitSeen;
    int          expLat, lat, cycles, stallErr, reqPulses, reqBadPos, hitPulses;
    logic [15:0] expData, gotData;
    logic        gotHit;
    xfer_t       expQ[$];

    tag = a[15:7];
    idx = a[6:3];
    w   = a[2:1];
    expHit      = refValid[idx] && (refTag[idx] == tag);
    dirtyVictim = !expHit && refValid[idx] && refDirty[idx];
    expQ.delete();
    if (!expHit) begin
      if (dirtyVictim)
        for (int k = 0; k < 4; k++) begin
          expQ.push_back('{1'b1, {refTag[idx], idx, 2'(k), 1'b0}, refData[idx][k]});
          refMem[{refTag[idx], idx, 2'(k)}] = refData[idx][k];
        end
      for (int k = 0; k < 4; k++) begin
        expQ.push_back('{1'b0, {tag, idx, 2'(k), 1'b0}, 16'h0});
        refData[idx][k] = refMem[{tag, idx, 2'(k)}];
      end
      refTag[idx]   = tag;
      refValid[idx] = 1'b1;
      refDirty[idx] = 1'b0;
    end
    expLat = expHit ? 1 : (2 + (dirtyVictim ? 8 : 4) * (ackDelay + 1));
    if (isWr) begin
      refData[idx][w] = d;
      refDirty[idx]   = 1'b1;
    end
    expData = refData[idx][w];

    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Stall !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle got Done=%b Stall=%b want 0 0", name, Done, Stall);
    end
    memLog.delete();
    Addr   = a;
    DataIn = d;
    Wr     = isWr;
    Rd     = !isWr || both;
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0;
    Addr = 16'($urandom); DataIn = 16'($urandom);

    got = 1'b0; cycles = 0; stallErr = 0; reqPulses = 0; reqBadPos = 0; hitPulses = 0;
    lat = 0; gotData = '0; gotHit = 1'b0; dcHitSeen = 1'b0;
    while (!got && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (DCacheReq === 1'b1) begin
        reqPulses++;
        if (cycles != 1) reqBadPos++;
      end
      if (DCacheHit === 1'b1) hitPulses++;
      if (Done === 1'b1) begin
        got = 1'b1; lat = cycles; gotData = DataOut; gotHit = CacheHit;
        dcHitSeen = (DCacheHit === 1'b1);
        if (Stall !== 1'b0) stallErr++;
      end else if (Stall !== 1'b1) stallErr++;
    end

    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout no Done within %0d cycles", name, cycles);
    end else begin
      checks++;
      if (lat != expLat) begin
        failures++;
        $display("FAIL %s_latency got=%0d want=%0d", name, lat, expLat);
      end
      checks++;
      if (gotHit !== expHit) begin
        failures++;
        $display("FAIL %s_cachehit got=%b want=%b", name, gotHit, expHit);
      end
      if (!isWr) begin
        checks++;
        if (gotData !== expData) begin
          failures++;
          $display("FAIL %s_dataout got=%h want=%h", name, gotData, expData);
        end
      end
      checks++;
      if (dcHitSeen !== (PERF && expHit) || hitPulses != int'(PERF && expHit)) begin
        failures++;
        $display("FAIL %s_dcachehit got pulses=%0d atDone=%b want %0d", name, hitPulses,
                 dcHitSeen, int'(PERF && expHit));
      end
    end
    checks++;
    if (reqPulses != int'(PERF) || reqBadPos != 0) begin
      failures++;
      $display("FAIL %s_dcachereq got pulses=%0d misplaced=%0d want %0d", name, reqPulses,
               reqBadPos, int'(PERF));
    end
    checks++;
    if (stallErr != 0) begin
      failures++;
      $display("FAIL %s_stall got %0d bad cycles want 0", name, stallErr);
    end
    checks++;
    if (memLog.size() != expQ.size()) begin
      failures++;
      $display("FAIL %s_memcount got=%0d want=%0d", name, memLog.size(), expQ.size());
    end else begin
      for (int k = 0; k < expQ.size(); k++) begin
        checks++;
        if (memLog[k].we !== expQ[k].we || memLog[k].addr !== expQ[k].addr ||
            (expQ[k].we && memLog[k].wdata !== expQ[k].wdata)) begin
          failures++;
          $display("FAIL %s_memxfer%0d got we=%b a=%h d=%h want we=%b a=%h d=%h", name, k,
                   memLog[k].we, memLog[k].addr, memLog[k].wdata,
                   expQ[k].we, expQ[k].addr, expQ[k].wdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({Done, Stall, CacheHit, DCacheReq, DCacheHit, memIf.mem_req, memIf.mem_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000000",
               {Done, Stall, CacheHit, DCacheReq, DCacheHit, memIf.mem_req, memIf.mem_we});
    end
    checks++;
    if (DataOut !== 16'h0) begin
      failures++;
      $display("FAIL reset_dataout got=%h want=0000", DataOut);
    end
    checks++;
    if (memIf.mem_addr !== 16'h0 || memIf.mem_wdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_membus got addr=%h wdata=%h want 0 0", memIf.mem_addr, memIf.mem_wdata);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_miss();
    ackDelay = 0;
    run_access(1'b0, 1'b0, 16'h0010, 16'h0, "clean_miss");
  endtask

  task automatic test_hit();
    run_access(1'b0, 1'b0, 16'h0012, 16'h0, "hit");
  endtask

  task automatic test_writeback();
    run_access(1'b1, 1'b0, 16'h0012, 16'hBEEF, "store_hit");
    run_access(1'b0, 1'b0, 16'h0812, 16'h0, "dirty_miss");
    checks++;
    if (memLog.size() < 2 || memLog[1].wdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL wb_word1 got=%h want=beef", (memLog.size() >= 2) ? memLog[1].wdata : 16'hxxxx);
    end
  endtask

  task automatic test_stray_ack();
    strayAck = 1'b1;
    run_access(1'b0, 1'b0, 16'h0812, 16'h0, "stray_hit");
    run_access(1'b1, 1'b1, 16'h0036, 16'h1234, "stray_miss_store");
    run_access(1'b0, 1'b0, 16'h0036, 16'h0, "stray_reload");
    strayAck = 1'b0;
  endtask

  task automatic test_slow_mem();
    ackDelay = 3;
    run_access(1'b0, 1'b0, 16'h0020, 16'h0, "slow_clean_miss");
    ackDelay = 0;
  endtask

  task automatic test_reset_mid_alloc();
    bit sawDone;
    ackDelay = 0;
    sawDone = 1'b0;
    @(negedge clk);
    Addr = 16'h0058; Rd = 1'b1;
    @(posedge clk);
    #1 Rd = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (Done === 1'b1) sawDone = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (Done === 1'b1) sawDone = 1'b1;
    checks++;
    if (memIf.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL abort_memreq got=%b want=0", memIf.mem_req);
    end
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      if (Done === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      failures++;
      $display("FAIL abort_done got Done pulse want none");
    end
    run_access(1'b0, 1'b0, 16'h0058, 16'h0, "after_abort");
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit          wr;
    for (int n = 0; n < 80; n++) begin
      a  = {9'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 1'($urandom)};
      wr = 1'($urandom);
      ackDelay = $urandom_range(0, 2);
      run_access(wr, 1'($urandom), a, 16'($urandom), "random");
    end
    ackDelay = 0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      backMem[i] = 16'($urandom);
      refMem[i]  = backMem[i];
    end
    test_reset();
    test_clean_miss();
    test_hit();
    test_writeback();
    test_stray_ack();
    test_slow_mem();
    test_reset_mid_alloc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, index width; 2^INDEX_W lines, tag width 13-INDEX_W.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Addr  in  16  byte address; [0] ignored, [2:1] word offset, [INDEX_W+2:3] index, upper bits tag.
REQ-005 DataIn  in  16  store data.
REQ-006 Rd  in  1  load request.
REQ-007 Wr  in  1  store request.
REQ-008 DataOut  out  16  load data, valid when Done=1.
REQ-009 Done  out  1  one-cycle completion pulse.
REQ-010 Stall  out  1  controller busy; pipeline holds memory stage.
REQ-011 CacheHit  out  1  qualifies Done: access hit.
REQ-012 DCacheReq  out  1  perf pulse, one per accepted access.
REQ-013 DCacheHit  out  1  perf pulse, one per hit.
REQ-014 mem_req  out  1  backing-memory word request.
REQ-015 mem_we  out  1  1=write-back word, 0=fill word.
REQ-016 mem_addr  out  16  word-aligned memory address.
REQ-017 mem_wdata  out  16  write-back data.
REQ-018 mem_ack  in  1  request completed on this edge; mem_rdata valid.
REQ-019 mem_rdata  in  16  fill data.

Function
REQ-020 Direct-mapped, write-back, write-allocate; 4 words/line; per line: valid, dirty, tag, 4x16 data.
REQ-021 States IDLE, COMPARE, WB, ALLOC, DONE; one access in flight.
REQ-022 IDLE: Stall=0; Rd|Wr sampled; request accepted latches Addr, DataIn, Wr (Wr wins if both high) -> COMPARE.
REQ-023 Inputs changing after acceptance SHALL not affect the access in flight.
REQ-024 COMPARE hit (valid & tag match): Done=1, CacheHit=1, Stall=0; load drives word to DataOut; store writes word, sets dirty -> IDLE.
REQ-025 COMPARE miss: Stall=1; victim valid&dirty -> WB, else -> ALLOC.
REQ-026 WB: words 0..3 in order, mem_we=1, mem_addr={victim tag, index, word, 0}; word counter advances on mem_ack; after word 3 ack -> ALLOC.
REQ-027 ALLOC: words 0..3, mem_we=0, mem_addr={new tag, index, word, 0}; mem_rdata written to line on each ack; after word 3: tag updated, valid=1, dirty=0 -> DONE.
REQ-028 mem_req=1 and mem_addr stable throughout WB/ALLOC until ack; back-to-back acks (one word/cycle) SHALL be supported.
REQ-029 DONE: Done=1, CacheHit=0, Stall=0; load returns filled word; store writes word, sets dirty -> IDLE.
REQ-030 Stall=1 in COMPARE-miss, WB, ALLOC; 0 otherwise.
REQ-031 Latency from accept edge, mem_ack tied high: hit Done at +1 cycle; clean miss +6; dirty miss +10.
REQ-032 DCacheReq=1 exactly in the first COMPARE cycle of each access; DCacheHit=1 exactly in hit-Done cycle.
REQ-033 mem_ack outside WB/ALLOC SHALL be ignored.

Reset
REQ-034 rst at an edge: state IDLE, all valid and dirty bits cleared, word counter 0; data/tag arrays not cleared.
REQ-035 During/after reset cycle: Done, Stall, CacheHit, DCacheReq, DCacheHit, mem_req, mem_we = 0; DataOut, mem_addr, mem_wdata = 0.
REQ-036 Reset mid-WB/ALLOC SHALL abort the access; mem_req low the cycle after the reset edge; no Done pulse.

Configuration
REQ-037 Macro DCACHE_PERF_EN defined: DCacheReq/DCacheHit behave per REQ-032.
REQ-038 Macro undefined: DCacheReq and DCacheHit tied 0; all other behaviour identical.

Structure
REQ-039 Package dcache_pkg SHALL hold state encoding, offset/word-count constants, and the 4-word line size.
REQ-040 Sub-module dcache_line_store SHALL hold valid/dirty/tag/data arrays with combinational read, single write port.

Verification
REQ-041 Reset, Rd Addr=0x0010 -> Stall until Done, CacheHit=0, mem reads 0x0010,0x0012,0x0014,0x0016, DataOut=mem[0x0010].
REQ-042 Repeat Rd 0x0012 -> Done at +1 cycle, CacheHit=1, DCacheHit=1, no mem_req.
REQ-043 Wr 0x0012=0xBEEF, then Rd 0x0812 (same index) -> write-back 0x0010..0x0016 with word 1=0xBEEF before fill of 0x0810..0x0816.
REQ-044 mem_ack delayed 3 cycles per word -> mem_addr stable while waiting, clean miss Done at +18.
REQ-045 rst asserted in 2nd ALLOC cycle -> no Done, mem_req 0 next cycle, following Rd same address misses.
REQ-046 Build without DCACHE_PERF_EN, run REQ-041/042 -> identical Done/DataOut, DCacheReq=DCacheHit=0 throughout.
